pong_match_controller: RTL and testbench
========================================

# pong_match_controller

Match sequencer for the Pong datapath, clocked by the 25 MHz pixel clock. It decides when the ball may move and when it is re-centred. It owns both BCD-range scores, serves alternately after each point and declares a winner. The ball/paddle datapath reports points and obeys `ball_run` and `ball_recenter`; the score digits feed the two `number_gen` instances directly.

## Interface
- `WIN_SCORE`, default 9: score (1..9) that ends the match.
- `SERVE_FRAMES`, default 60: frames the ball is held centred before each serve (1..1023).
- `POINT_FRAMES`, default 30: frames of freeze after a point (1..1023).
- `clock_25M` input, 1 bit: pixel clock; all logic rising-edge.
- `reset_n` input, 1 bit: asynchronous, active-low reset.
- `frame` input, 1 bit: one-cycle pulse at the start of vertical blanking.
- `btn_start` input, 1 bit: start button, level, already synchronous to `clock_25M`.
- `point_left` input, 1 bit: one-cycle pulse; ball exited the right edge, left player scores.
- `point_right` input, 1 bit: one-cycle pulse; ball exited the left edge, right player scores.
- `ball_run` output, 1 bit: datapath may advance ball position on `frame`.
- `ball_recenter` output, 1 bit: one-cycle pulse; datapath loads ball to (320,240).
- `serve_right` output, 1 bit: initial horizontal direction for the next serve (1 = toward right).
- `score_left` output, 4 bits: left score, 0..WIN_SCORE.
- `score_right` output, 4 bits: right score, 0..WIN_SCORE.
- `game_over` output, 1 bit: high in GAME_OVER.
- `winner_left` output, 1 bit: valid while `game_over`; 1 = left player won.

## Operation
- States:
  - IDLE: ball frozen, scores shown.
  - SERVE: count SERVE_FRAMES frames.
  - PLAY: ball runs.
  - POINT: count POINT_FRAMES frames.
  - GAME_OVER: ball frozen, winner shown.
- IDLE -> SERVE on a `btn_start` rising edge, detected with an internal 1-cycle delay register. On that edge: scores cleared to 0, `ball_recenter` pulsed, frame counter cleared, `serve_right` = 1.
- SERVE: frame counter increments on each `frame`. When the count reaches SERVE_FRAMES, go to PLAY with `ball_run` = 1.
- PLAY -> POINT on `point_left` or `point_right`:
  - The scorer's score increments; `ball_run` drops and the counter clears.
  - `serve_right` is set toward the conceded player: 1 if left scored, 0 if right scored.
  - If `point_left` and `point_right` arrive in the same cycle: no score change, `serve_right` toggles, go to POINT.
- POINT: after POINT_FRAMES frames:
  - If either score equals WIN_SCORE, go to GAME_OVER and latch `winner_left`.
  - Otherwise pulse `ball_recenter` and go to SERVE.
- GAME_OVER -> IDLE on a `btn_start` rising edge. Scores are held until the next IDLE -> SERVE.
- Point pulses outside PLAY are ignored.
- A `btn_start` edge outside IDLE/GAME_OVER is ignored.
- Scores saturate at WIN_SCORE and never exceed 9.
- Frame counter is 10 bits and cannot wrap: it is cleared on every state entry and compared for equality.
- Illegal state encoding -> IDLE on the next clock.

## Timing
- Reset values: state IDLE, `ball_run` 0, `ball_recenter` 0, `serve_right` 1, `score_left` 0, `score_right` 0, `game_over` 0, `winner_left` 0, counter 0, start-edge register 0.
- All outputs are registered and change 1 cycle after the causing input edge. For example, `point_left` high at edge N gives the score increment and `ball_run` = 0 visible after edge N+1.
- `ball_recenter` is high for exactly one `clock_25M` cycle.
- Frame timing from `btn_start` edge:
  - SERVE lasts SERVE_FRAMES `frame` pulses.
  - `ball_run` rises the cycle after the SERVE_FRAMES-th `frame` pulse.
  - The first ball move is therefore on the following frame.
- Reset asserted mid-operation: all state clears immediately (asynchronous). Release is synchronous to the next rising edge, with no spurious `ball_recenter`.

## Configuration
- Macro: `PONG_AUTO_SERVE_EN`.
- Defined:
  - IDLE -> SERVE happens automatically after SERVE_FRAMES frames in IDLE, in addition to the `btn_start` edge (attract mode).
  - GAME_OVER -> IDLE happens automatically after 4*POINT_FRAMES frames, in addition to the `btn_start` edge.
- Undefined: IDLE and GAME_OVER are left only on a `btn_start` rising edge; the counter is held at 0 in those states.

## Test plan
- Reset, then `btn_start` held high 10 cycles:
  - Exactly one `ball_recenter` pulse, state SERVE.
  - With SERVE_FRAMES=2: `ball_run` = 1 one cycle after the 2nd `frame`.
- In PLAY, pulse `point_left`:
  - `score_left` 0->1, `ball_run` 0, `serve_right` 1.
  - After POINT_FRAMES frames: one `ball_recenter` pulse, then SERVE.
- In PLAY, `point_left` and `point_right` in the same cycle: scores unchanged, `serve_right` toggled, POINT entered.
- With WIN_SCORE=3, right scores 3 times:
  - `game_over` = 1 and `winner_left` = 0 after the 3rd POINT period.
  - Further point pulses leave `score_right` at 3.
  - `btn_start` edge -> IDLE; next edge clears both scores.
- Drop `reset_n` mid-SERVE (counter 5): all outputs at reset values the same cycle; after release, no activity without `btn_start`.
- With `PONG_AUTO_SERVE_EN` defined, SERVE_FRAMES=2, no button: IDLE -> SERVE after 2 frames, with `ball_recenter` pulsed.

Source files
------------

// File: rtl/pong_match_controller_if.sv
// Datapath <-> match controller signal bundle for the Pong core.
// The controller sits on the slave side; the ball/paddle datapath (or a bench) on the master side.
interface pong_match_controller_if;
  logic       frame;
  logic       btn_start;
  logic       point_left;
  logic       point_right;
  logic       ball_run;
  logic       ball_recenter;
  logic       serve_right;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic       winner_left;

  modport master (
    output frame, btn_start, point_left, point_right,
    input  ball_run, ball_recenter, serve_right, score_left, score_right,
           game_over, winner_left
  );

  modport slave (
    input  frame, btn_start, point_left, point_right,
    output ball_run, ball_recenter, serve_right, score_left, score_right,
           game_over, winner_left
  );
endinterface

// File: rtl/pong_match_controller.sv
// Pong match sequencer: serve / play / point / game-over flow and the two BCD scores.
// Define PONG_AUTO_SERVE_EN for attract mode (automatic serve from IDLE and return from GAME_OVER).
module pong_match_controller #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 30
) (
  input  logic                          clock_25M,
  input  logic                          reset_n,
  pong_match_controller_if.slave        bus
);

`ifdef PONG_AUTO_SERVE_EN
  // Attract mode waits 4*POINT_FRAMES in GAME_OVER, which needs two extra counter bits.
  localparam int unsigned CNT_W = 12;
  localparam logic [CNT_W-1:0] OVER_LAST = CNT_W'(4 * POINT_FRAMES - 1);
`else
  localparam int unsigned CNT_W = 10;
`endif
  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] POINT_LAST = CNT_W'(POINT_FRAMES - 1);
  localparam logic [3:0]       WIN        = 4'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  state_e           state_q;
  logic             start_q;
  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             recenter_q;
  logic             serve_right_q;
  logic [3:0]       score_l_q;
  logic [3:0]       score_r_q;
  logic             over_q;
  logic             winner_l_q;

  logic start_edge_c;
  logic begin_match_c;
  logic leave_over_c;

  assign start_edge_c = bus.btn_start & ~start_q;

`ifdef PONG_AUTO_SERVE_EN
  assign begin_match_c = (state_q == S_IDLE) &&
                         (start_edge_c || (bus.frame && (cnt_q == SERVE_LAST)));
  assign leave_over_c  = (state_q == S_OVER) &&
                         (start_edge_c || (bus.frame && (cnt_q == OVER_LAST)));
`else
  assign begin_match_c = (state_q == S_IDLE) && start_edge_c;
  assign leave_over_c  = (state_q == S_OVER) && start_edge_c;
`endif

  always_ff @(posedge clock_25M or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      start_q       <= 1'b0;
      cnt_q         <= '0;
      run_q         <= 1'b0;
      recenter_q    <= 1'b0;
      serve_right_q <= 1'b1;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      over_q        <= 1'b0;
      winner_l_q    <= 1'b0;
    end else begin
      start_q    <= bus.btn_start;
      recenter_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (begin_match_c) begin
            state_q       <= S_SERVE;
            cnt_q         <= '0;
            score_l_q     <= 4'd0;
            score_r_q     <= 4'd0;
            serve_right_q <= 1'b1;
            recenter_q    <= 1'b1;
`ifdef PONG_AUTO_SERVE_EN
          end else if (bus.frame) begin
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        S_SERVE: begin
          if (bus.frame) begin
            if (cnt_q == SERVE_LAST) begin
              state_q <= S_PLAY;
              cnt_q   <= '0;
              run_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_PLAY: begin
          if (bus.point_left || bus.point_right) begin
            state_q <= S_POINT;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            // A simultaneous exit on both edges is a let: no score, serve flips.
            if (bus.point_left && bus.point_right) begin
              serve_right_q <= ~serve_right_q;
            end else if (bus.point_left) begin
              serve_right_q <= 1'b1;
              if (score_l_q < WIN) score_l_q <= score_l_q + 4'd1;
            end else begin
              serve_right_q <= 1'b0;
              if (score_r_q < WIN) score_r_q <= score_r_q + 4'd1;
            end
          end
        end
        S_POINT: begin
          if (bus.frame) begin
            if (cnt_q == POINT_LAST) begin
              cnt_q <= '0;
              if ((score_l_q == WIN) || (score_r_q == WIN)) begin
                state_q    <= S_OVER;
                over_q     <= 1'b1;
                winner_l_q <= (score_l_q == WIN);
              end else begin
                state_q    <= S_SERVE;
                recenter_q <= 1'b1;
              end
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        S_OVER: begin
          if (leave_over_c) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            over_q     <= 1'b0;
            winner_l_q <= 1'b0;
`ifdef PONG_AUTO_SERVE_EN
          end else if (bus.frame) begin
            cnt_q <= cnt_q + CNT_W'(1);
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          run_q   <= 1'b0;
          over_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ball_run      = run_q;
  assign bus.ball_recenter = recenter_q;
  assign bus.serve_right   = serve_right_q;
  assign bus.score_left    = score_l_q;
  assign bus.score_right   = score_r_q;
  assign bus.game_over     = over_q;
  assign bus.winner_left   = winner_l_q;

endmodule

// File: tb/tb_pong_match_controller.sv
// Bench for pong_match_controller: directed match scenarios then random play,
// all outputs checked every cycle against a rule-level match model.
module tb_pong_match_controller;
  localparam int WIN = 3;
  localparam int SF  = 2;
  localparam int PF  = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #20 clk = ~clk;

  pong_match_controller_if bus ();

  pong_match_controller #(
    .WIN_SCORE(WIN), .SERVE_FRAMES(SF), .POINT_FRAMES(PF)
  ) dut (
    .clock_25M(clk),
    .reset_n  (rst_n),
    .bus      (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Match model: phase of the match, frames seen in the phase, scores and serve side.
  typedef enum {M_IDLE, M_SERVE, M_PLAY, M_POINT, M_OVER} mode_e;
  mode_e m_mode;
  int    m_frames, m_sl, m_sr;
  bit    m_dir, m_rc, m_winl, m_btn_prev;
  bit    btn_lvl;

  function automatic void model_reset();
    m_mode = M_IDLE; m_frames = 0; m_sl = 0; m_sr = 0;
    m_dir = 1'b1; m_rc = 1'b0; m_winl = 1'b0; m_btn_prev = 1'b0;
  endfunction

  function automatic void model_go(input mode_e nm);
    m_mode = nm;
    m_frames = 0;
  endfunction

  function automatic void model_start();
    m_sl = 0; m_sr = 0; m_dir = 1'b1; m_rc = 1'b1;
    model_go(M_SERVE);
  endfunction

  function automatic void model_step(input bit f, input bit b, input bit pl, input bit pr);
    bit rise;
    rise = b && !m_btn_prev;
    m_btn_prev = b;
    m_rc = 1'b0;
    case (m_mode)
      M_IDLE: begin
`ifdef PONG_AUTO_SERVE_EN
        if (f) m_frames++;
        if (rise || m_frames == SF) model_start();
`else
        if (rise) model_start();
`endif
      end
      M_SERVE: if (f) begin
        m_frames++;
        if (m_frames == SF) model_go(M_PLAY);
      end
      M_PLAY: begin
        if (pl && pr) begin
          m_dir = !m_dir; model_go(M_POINT);
        end else if (pl) begin
          m_sl = (m_sl < WIN) ? m_sl + 1 : m_sl; m_dir = 1'b1; model_go(M_POINT);
        end else if (pr) begin
          m_sr = (m_sr < WIN) ? m_sr + 1 : m_sr; m_dir = 1'b0; model_go(M_POINT);
        end
      end
      M_POINT: if (f) begin
        m_frames++;
        if (m_frames == PF) begin
          if (m_sl == WIN || m_sr == WIN) begin
            m_winl = (m_sl == WIN); model_go(M_OVER);
          end else begin
            m_rc = 1'b1; model_go(M_SERVE);
          end
        end
      end
      M_OVER: begin
`ifdef PONG_AUTO_SERVE_EN
        if (f) m_frames++;
        if (rise || m_frames == 4 * PF) begin m_winl = 1'b0; model_go(M_IDLE); end
`else
        if (rise) begin m_winl = 1'b0; model_go(M_IDLE); end
`endif
      end
      default: model_go(M_IDLE);
    endcase
  endfunction

  task automatic compare_all();
    check_eq("ball_run",      int'(bus.ball_run),      int'(m_mode == M_PLAY));
    check_eq("ball_recenter", int'(bus.ball_recenter), int'(m_rc));
    check_eq("serve_right",   int'(bus.serve_right),   int'(m_dir));
    check_eq("score_left",    int'(bus.score_left),    m_sl);
    check_eq("score_right",   int'(bus.score_right),   m_sr);
    check_eq("game_over",     int'(bus.game_over),     int'(m_mode == M_OVER));
    check_eq("winner_left",   int'(bus.winner_left),   int'(m_winl));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check just after it.
  task automatic step(input bit f, input bit b, input bit pl, input bit pr);
    bus.frame = f; bus.btn_start = b; bus.point_left = pl; bus.point_right = pr;
    @(posedge clk);
    model_step(f, b, pl, pr);
    #1;
    compare_all();
  endtask

  task automatic frames(input int n, output int rc);
    rc = 0;
    repeat (n) begin
      step(1'b1, btn_lvl, 1'b0, 1'b0);
      rc += int'(bus.ball_recenter);
      step(1'b0, btn_lvl, 1'b0, 1'b0);
      rc += int'(bus.ball_recenter);
    end
  endtask

  initial begin
    int rc;
    rst_n = 1'b0;
    bus.frame = 1'b0; bus.btn_start = 1'b0; bus.point_left = 1'b0; bus.point_right = 1'b0;
    btn_lvl = 1'b0;
    model_reset();
    #45;
    compare_all();
    @(posedge clk); #1 rst_n = 1'b1;

    // Held start button: one recenter, then serve countdown.
    btn_lvl = 1'b1;
    rc = 0;
    repeat (10) begin
      step(1'b0, btn_lvl, 1'b0, 1'b0);
      rc += int'(bus.ball_recenter);
    end
    check_eq("start_recenter_count", rc, 1);
    step(1'b1, btn_lvl, 1'b0, 1'b0);
    check_eq("run_before_last_frame", int'(bus.ball_run), 0);
    step(1'b0, btn_lvl, 1'b0, 1'b0);
    step(1'b1, btn_lvl, 1'b0, 1'b0);
    check_eq("run_after_2nd_frame", int'(bus.ball_run), 1);

    // Left scores.
    step(1'b0, btn_lvl, 1'b1, 1'b0);
    check_eq("left_point_score", int'(bus.score_left), 1);
    check_eq("left_point_run", int'(bus.ball_run), 0);
    check_eq("left_point_serve", int'(bus.serve_right), 1);
    frames(PF, rc);
    check_eq("point_recenter_count", rc, 1);
    frames(SF, rc);
    check_eq("replay_run", int'(bus.ball_run), 1);

    // Simultaneous exits: no score, serve toggles.
    step(1'b0, btn_lvl, 1'b1, 1'b1);
    check_eq("let_score_left", int'(bus.score_left), 1);
    check_eq("let_score_right", int'(bus.score_right), 0);
    check_eq("let_serve_toggle", int'(bus.serve_right), 0);
    check_eq("let_run_drop", int'(bus.ball_run), 0);
    frames(PF, rc);
    frames(SF, rc);

    // Right wins the match.
    for (int k = 0; k < WIN; k++) begin
      step(1'b0, btn_lvl, 1'b0, 1'b1);
      frames(PF, rc);
      if (k < WIN - 1) frames(SF, rc);
    end
    check_eq("over_flag", int'(bus.game_over), 1);
    check_eq("over_winner", int'(bus.winner_left), 0);
    step(1'b0, btn_lvl, 1'b0, 1'b1);
    step(1'b0, btn_lvl, 1'b1, 1'b1);
    check_eq("over_score_right_held", int'(bus.score_right), WIN);
    btn_lvl = 1'b0; step(1'b0, btn_lvl, 1'b0, 1'b0);
    btn_lvl = 1'b1; step(1'b0, btn_lvl, 1'b0, 1'b0);
    check_eq("idle_over_clear", int'(bus.game_over), 0);
    check_eq("idle_scores_held", int'(bus.score_right), WIN);
    btn_lvl = 1'b0; step(1'b0, btn_lvl, 1'b0, 1'b0);
    btn_lvl = 1'b1; step(1'b0, btn_lvl, 1'b0, 1'b0);
    check_eq("restart_score_left", int'(bus.score_left), 0);
    check_eq("restart_score_right", int'(bus.score_right), 0);

    // Asynchronous reset mid-serve.
    step(1'b1, btn_lvl, 1'b0, 1'b0);
    #5 rst_n = 1'b0;
    #1;
    model_reset();
    check_eq("rst_recenter", int'(bus.ball_recenter), 0);
    check_eq("rst_serve_right", int'(bus.serve_right), 1);
    check_eq("rst_scores", int'({bus.score_left, bus.score_right}), 0);
    compare_all();
    btn_lvl = 1'b0;
    bus.btn_start = 1'b0;
    @(posedge clk); #7 rst_n = 1'b1;
    rc = 0;
    repeat (20) begin
      step(1'($urandom_range(0, 1)), btn_lvl, 1'b0, 1'b0);
      rc += int'(bus.ball_recenter);
    end
`ifndef PONG_AUTO_SERVE_EN
    check_eq("post_reset_quiet", rc, 0);
`endif

    // Random play.
    for (int i = 0; i < 3000; i++) begin
      bit f, pl, pr;
      f  = ($urandom_range(0, 3) == 0);
      pl = ($urandom_range(0, 15) == 0);
      pr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 19) == 0) btn_lvl = !btn_lvl;
      step(f, btn_lvl, pl, pr);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
